dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (loader/debug DMA).
//  Round-robin arbitration, one-deep registered issue stage, registered read return.
//  Sits between the requesters and data_Memory, and is the only driver of its address, write_Data, memRead and memWrite.
//  Sustains one access per cycle: fixed 2-cycle read latency, 1-cycle write commit.
// PARAMETERS
//  DEPTH      64  number of memory words; word-indexed address space 0..DEPTH-1
//  ADDR_W     32  requester/memory address width
//  DATA_W     32  data width
//  FIXED_PRI  0   1 = port 0 always wins a conflict; 0 = round-robin
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  reset       in   1       synchronous, active-high
//  req0/req1   in   1       access request; held with its addr/data/we until gnt
//  we0/we1     in   1       1 = write, 0 = read
//  addr0/addr1 in   ADDR_W  word address
//  wdata0/1    in   DATA_W  write data
//  gnt0/gnt1   out  1       combinational accept; request is latched at this posedge
//  rvalid0/1   out  1       1-cycle pulse: rdata is valid for that port
//  rdata       out  DATA_W  registered read data (shared by both ports)
//  err0/err1   out  1       1-cycle pulse with rvalid timing: address >= DEPTH
//  mem_addr    out  ADDR_W  to data_Memory address
//  mem_wdata   out  DATA_W  to data_Memory write_Data
//  mem_rd      out  1       to data_Memory memRead
//  mem_wr      out  1       to data_Memory memWrite
//  mem_rdata   in   DATA_W  from data_Memory read_Data (combinational)
// BEHAVIOUR
//  Reset (sync): issue_valid=0, last_gnt=1 (so port 0 wins the first conflict), rvalid*=0, err*=0, rdata=0,
//   mem_rd=mem_wr=0, mem_addr=mem_wdata=0. Reset overrides everything; an in-flight access is dropped (no commit, no rvalid).
//  Arbitration, cycle N (combinational):
//   - One request only: that port is granted.
//   - Both requesting: FIXED_PRI=1 -> port 0. FIXED_PRI=0 -> the port != last_gnt.
//   - At most one gnt per cycle. No gnt while reset=1.
//   - A request may be withdrawn before it is granted; no state is affected.
//  Issue, posedge ending N: issue_{valid,port,we,addr,wdata} <= granted request; last_gnt <= granted port.
//   With no grant, issue_valid <= 0.
//  Access, cycle N+1: mem_addr/mem_wdata come from the issue register.
//   - mem_wr = issue_valid & we & in_range.  mem_rd = issue_valid & ~we & in_range.  in_range = addr < DEPTH.
//   - Out-of-range accesses drive mem_rd=mem_wr=0 (memory untouched).
//  Return, posedge ending N+1: for reads, rdata <= mem_rdata (out of range: rdata <= 0).
//   Writes leave rdata unchanged. Cycle N+2: rvalid<port> = 1 for reads only; err<port> = 1 for any out-of-range access.
//  Back-to-back: a new grant in N+1 issues in N+2, so there is no bubble.
//   Write at N followed by read of the same address at N+1 returns the new data (write commits before the read's access cycle).
//  Round-robin guarantees: with both ports continuously requesting, grants alternate 0,1,0,1...; no port waits more than 1 cycle.
//  No internal FSM beyond the issue/return registers; the pipeline is IDLE/ISSUE per issue_valid.
// STRUCTURE
//  Package dmem_arb_pkg: DEPTH, ADDR_W, DATA_W defaults; PORT_CPU=0, PORT_DMA=1 constants.
//  Sub-module rr_arb2 (inputs: req[1:0], last, fixed_pri; output: one-hot gnt[1:0]), purely combinational.
//   last_gnt is held in the parent.
//  Parent holds the issue register, return register, last_gnt and the range check.
// TESTING
//  1. Reset, then req0 read addr=5 -> gnt0 at N, mem_rd=1 at N+1, rvalid0=1 and rdata=87 at N+2 (memory reset image).
//  2. req0 write addr=21 data=0xDEAD at N, req0 read addr=21 at N+1
//     -> mem_wr=1 at N+1, rvalid0 at N+3 with rdata=0xDEAD.
//  3. req0 and req1 held high for 6 cycles after reset (FIXED_PRI=0) -> gnt pattern 0,1,0,1,0,1.
//     With FIXED_PRI=1 -> gnt0 every cycle, gnt1 never.
//  4. req1 read addr=64 -> gnt1, mem_rd=0 and mem_wr=0 at N+1, err1=1 and rvalid1=1 with rdata=0 at N+2.
//  5. req1 write addr=30 granted at N, reset=1 at N+1
//     -> mem_wr=0 at N+1, no rvalid/err, addr 30 reads back 0 after reset.
//  6. req0 asserted then dropped while req1 is granted
//     -> no gnt0 or rvalid0 ever; last_gnt advances only on actual grants.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared defaults and port identifiers for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_DEPTH  = 64;
    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester combinational arbiter: round-robin on last grant, or port 0 priority.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    input  logic       fixed_pri,
    output logic [1:0] gnt
);

    logic cpu_wins;

    // The CPU takes a conflict when it has priority or the DMA port was served last.
    always_comb begin
        cpu_wins      = req[PORT_CPU] & (~req[PORT_DMA] | fixed_pri | (last == PORT_DMA));
        gnt           = 2'b00;
        gnt[PORT_CPU] = cpu_wins;
        gnt[PORT_DMA] = req[PORT_DMA] & ~cpu_wins;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and loader/DMA (port 1):
// one-deep issue register feeding the memory, registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH     = DMEM_DEPTH,
    parameter int unsigned ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned DATA_W    = DMEM_DATA_W,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        req;
    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              any_gnt;
    port_e             sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    port_e             last_gnt_q,    last_gnt_d;
    logic              issue_valid_q, issue_valid_d;
    port_e             issue_port_q,  issue_port_d;
    logic              issue_we_q,    issue_we_d;
    logic              issue_oor_q,   issue_oor_d;
    logic [ADDR_W-1:0] issue_addr_q,  issue_addr_d;
    logic [DATA_W-1:0] issue_wdata_q, issue_wdata_d;
    logic              mem_rd_q,      mem_rd_d;
    logic              mem_wr_q,      mem_wr_d;
    logic [1:0]        rvalid_q,      rvalid_d;
    logic [1:0]        err_q,         err_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;

    assign req = {req1, req0};

    rr_arb2 u_arb (
        .req       (req),
        .last      (last_gnt_q),
        .fixed_pri (FIXED_PRI),
        .gnt       (arb_gnt)
    );

    // Nothing is accepted while reset is held.
    assign gnt     = reset ? 2'b00 : arb_gnt;
    assign any_gnt = |gnt;

    // Mux the winning request and range-check it before it enters the issue register.
    always_comb begin
        sel_port     = arb_gnt[PORT_DMA] ? PORT_DMA : PORT_CPU;
        sel_we       = (sel_port == PORT_DMA) ? we1    : we0;
        sel_addr     = (sel_port == PORT_DMA) ? addr1  : addr0;
        sel_wdata    = (sel_port == PORT_DMA) ? wdata1 : wdata0;
        sel_in_range = sel_addr < ADDR_W'(DEPTH);
    end

    always_comb begin
        last_gnt_d    = last_gnt_q;
        issue_valid_d = any_gnt;
        issue_port_d  = issue_port_q;
        issue_we_d    = issue_we_q;
        issue_oor_d   = issue_oor_q;
        issue_addr_d  = issue_addr_q;
        issue_wdata_d = issue_wdata_q;
        mem_rd_d      = any_gnt & ~sel_we & sel_in_range;
        mem_wr_d      = any_gnt &  sel_we & sel_in_range;
        rvalid_d      = 2'b00;
        err_d         = 2'b00;
        rdata_d       = rdata_q;

        if (any_gnt) begin
            last_gnt_d    = sel_port;
            issue_port_d  = sel_port;
            issue_we_d    = sel_we;
            issue_oor_d   = ~sel_in_range;
            issue_addr_d  = sel_addr;
            issue_wdata_d = sel_wdata;
        end

        // Return stage: capture read data in the access cycle; writes keep rdata.
        if (issue_valid_q) begin
            err_d[issue_port_q] = issue_oor_q;
            if (!issue_we_q) begin
                rvalid_d[issue_port_q] = 1'b1;
                rdata_d                = issue_oor_q ? '0 : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q    <= PORT_DMA;
            issue_valid_q <= 1'b0;
            issue_port_q  <= PORT_CPU;
            issue_we_q    <= 1'b0;
            issue_oor_q   <= 1'b0;
            issue_addr_q  <= '0;
            issue_wdata_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            rvalid_q      <= 2'b00;
            err_q         <= 2'b00;
            rdata_q       <= '0;
        end else begin
            last_gnt_q    <= last_gnt_d;
            issue_valid_q <= issue_valid_d;
            issue_port_q  <= issue_port_d;
            issue_we_q    <= issue_we_d;
            issue_oor_q   <= issue_oor_d;
            issue_addr_q  <= issue_addr_d;
            issue_wdata_q <= issue_wdata_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            rvalid_q      <= rvalid_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
        end
    end

    // An access already issued is dropped in the cycle reset arrives.
    assign mem_rd    = mem_rd_q & ~reset;
    assign mem_wr    = mem_wr_q & ~reset;
    assign mem_addr  = issue_addr_q;
    assign mem_wdata = issue_wdata_q;

    assign gnt0    = gnt[PORT_CPU];
    assign gnt1    = gnt[PORT_DMA];
    assign rvalid0 = rvalid_q[PORT_CPU];
    assign rvalid1 = rvalid_q[PORT_DMA];
    assign err0    = err_q[PORT_CPU];
    assign err1    = err_q[PORT_DMA];
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances on shared stimulus,
// each with its own memory, checked against a transaction-level reference model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_load;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [1:0]  g0_o, g1_o, rv0_o, rv1_o, e0_o, e1_o, mrd_o, mwr_o;
    logic [31:0] rdata_o  [2];
    logic [31:0] maddr_o  [2];
    logic [31:0] mwdata_o [2];
    logic [31:0] mrdata_i [2];
    logic [31:0] pmem     [2][64];

    dmem_arbiter #(.DEPTH(64), .ADDR_W(32), .DATA_W(32), .FIXED_PRI(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(g0_o[0]), .gnt1(g1_o[0]), .rvalid0(rv0_o[0]), .rvalid1(rv1_o[0]),
        .rdata(rdata_o[0]), .err0(e0_o[0]), .err1(e1_o[0]),
        .mem_addr(maddr_o[0]), .mem_wdata(mwdata_o[0]), .mem_rd(mrd_o[0]), .mem_wr(mwr_o[0]),
        .mem_rdata(mrdata_i[0])
    );

    dmem_arbiter #(.DEPTH(64), .ADDR_W(32), .DATA_W(32), .FIXED_PRI(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(g0_o[1]), .gnt1(g1_o[1]), .rvalid0(rv0_o[1]), .rvalid1(rv1_o[1]),
        .rdata(rdata_o[1]), .err0(e0_o[1]), .err1(e1_o[1]),
        .mem_addr(maddr_o[1]), .mem_wdata(mwdata_o[1]), .mem_rd(mrd_o[1]), .mem_wr(mwr_o[1]),
        .mem_rdata(mrdata_i[1])
    );

    function automatic logic [31:0] img(int a);
        return (a < 16) ? 32'(a * 16 + 7) : 32'd0;
    endfunction

    // Data memory stand-ins: combinational read, write on posedge when memWrite.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_load) begin
                for (int a = 0; a < 64; a++) pmem[k][a] <= img(a);
            end else if (mwr_o[k] && maddr_o[k] < 32'd64) begin
                pmem[k][maddr_o[k][5:0]] <= mwdata_o[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++)
            mrdata_i[k] = (maddr_o[k] < 32'd64) ? pmem[k][maddr_o[k][5:0]] : 32'hBAD0_BAD0;
    end

    // Reference model: a transaction granted in cycle c accesses memory in c+1, returns in c+2.
    typedef struct {
        bit          v;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        acc_m   [2];
    txn_t        ret_m   [2];
    bit          last_m  [2];
    logic [31:0] rdata_m [2];
    logic [31:0] mmem    [2][64];

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instance 1 always favours port 0; instance 0 favours whichever port was not served last.
    function automatic logic [1:0] exp_gnt(int k);
        if (reset) return 2'b00;
        if (req0 && req1) return (k == 1 || last_m[k]) ? 2'b01 : 2'b10;
        return {req1, req0};
    endfunction

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            logic [1:0] eg;
            bit         inr;
            eg  = exp_gnt(k);
            inr = acc_m[k].addr < 32'd64;
            chk($sformatf("gnt0[%0d]", k), g0_o[k], eg[0]);
            chk($sformatf("gnt1[%0d]", k), g1_o[k], eg[1]);
            chk($sformatf("mem_rd[%0d]", k), mrd_o[k], !reset && acc_m[k].v && !acc_m[k].we && inr);
            chk($sformatf("mem_wr[%0d]", k), mwr_o[k], !reset && acc_m[k].v && acc_m[k].we && inr);
            if (acc_m[k].v) chk($sformatf("mem_addr[%0d]", k), maddr_o[k], acc_m[k].addr);
            if (acc_m[k].v && acc_m[k].we) chk($sformatf("mem_wdata[%0d]", k), mwdata_o[k], acc_m[k].wdata);
            chk($sformatf("rvalid0[%0d]", k), rv0_o[k], ret_m[k].v && !ret_m[k].we && !ret_m[k].port);
            chk($sformatf("rvalid1[%0d]", k), rv1_o[k], ret_m[k].v && !ret_m[k].we && ret_m[k].port);
            chk($sformatf("err0[%0d]", k), e0_o[k], ret_m[k].v && ret_m[k].addr >= 32'd64 && !ret_m[k].port);
            chk($sformatf("err1[%0d]", k), e1_o[k], ret_m[k].v && ret_m[k].addr >= 32'd64 && ret_m[k].port);
            chk($sformatf("rdata[%0d]", k), rdata_o[k], rdata_m[k]);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic [1:0] eg;
            eg = exp_gnt(k);
            if (reset) begin
                acc_m[k].v = 1'b0;
                ret_m[k].v = 1'b0;
                last_m[k]  = 1'b1;
                rdata_m[k] = 32'd0;
            end else begin
                if (acc_m[k].v) begin
                    if (acc_m[k].addr < 32'd64 && acc_m[k].we)
                        mmem[k][acc_m[k].addr[5:0]] = acc_m[k].wdata;
                    if (!acc_m[k].we)
                        rdata_m[k] = (acc_m[k].addr < 32'd64) ? mmem[k][acc_m[k].addr[5:0]] : 32'd0;
                end
                ret_m[k]       = acc_m[k];
                acc_m[k].v     = |eg;
                acc_m[k].port  = eg[1];
                acc_m[k].we    = eg[1] ? we1    : we0;
                acc_m[k].addr  = eg[1] ? addr1  : addr0;
                acc_m[k].wdata = eg[1] ? wdata1 : wdata0;
                if (|eg) last_m[k] = eg[1];
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_p0(bit r, bit w, logic [31:0] a, logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set_p1(bit r, bit w, logic [31:0] a, logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic idle(int n);
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic do_reset();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        settle();
        advance();
        reset = 1'b0;
    endtask

    typedef struct {
        bit         r0;
        bit         r1;
        logic [1:0] eg;
        logic [1:0] egf;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[1]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[2]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[3]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[4]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[5]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[6]  = '{1'b0, 1'b1, 2'b10, 2'b10};
        tbl[7]  = '{1'b1, 1'b1, 2'b01, 2'b01};
        tbl[8]  = '{1'b1, 1'b0, 2'b01, 2'b01};
        tbl[9]  = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 2'b00};
        tbl[11] = '{1'b1, 1'b1, 2'b01, 2'b01};

        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mmem[k][a] = img(a);
            acc_m[k] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
            ret_m[k] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
            last_m[k]  = 1'b1;
            rdata_m[k] = 32'd0;
        end

        // Power-up: hold reset for two edges and load the memory image.
        reset    = 1'b1;
        mem_load = 1'b1;
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        advance();
        mem_load = 1'b0;
        advance();
        reset = 1'b0;

        settle();
        chk("rst_rvalid", {rv1_o[0], rv0_o[0]}, 32'd0);
        chk("rst_err", {e1_o[0], e0_o[0]}, 32'd0);
        chk("rst_rdata", rdata_o[0], 32'd0);
        chk("rst_mem_rdwr", {mwr_o[0], mrd_o[0]}, 32'd0);
        chk("rst_mem_addr", maddr_o[0], 32'd0);
        chk("rst_mem_wdata", mwdata_o[0], 32'd0);
        advance();

        // Grant sequences from reset, both arbitration modes.
        for (int i = 0; i < 12; i++) begin
            set_p0(tbl[i].r0, 1'b0, 32'(i), 32'd0);
            set_p1(tbl[i].r1, 1'b0, 32'(40 + i), 32'd0);
            settle();
            chk($sformatf("tbl%0d_gnt_rr", i), {g1_o[0], g0_o[0]}, tbl[i].eg);
            chk($sformatf("tbl%0d_gnt_fp", i), {g1_o[1], g0_o[1]}, tbl[i].egf);
            advance();
        end
        idle(3);

        // Single read, 2-cycle latency.
        do_reset();
        set_p0(1'b1, 1'b0, 32'd5, 32'd0);
        settle(); chk("t1_gnt0", g0_o[0], 32'd1); advance();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        settle(); chk("t1_mem_rd", mrd_o[0], 32'd1); chk("t1_mem_addr", maddr_o[0], 32'd5); advance();
        settle(); chk("t1_rvalid0", rv0_o[0], 32'd1); chk("t1_rdata", rdata_o[0], 32'd87); advance();

        // Write then read of the same word on consecutive grants.
        set_p0(1'b1, 1'b1, 32'd21, 32'hDEAD);
        settle(); chk("t2_gnt0_w", g0_o[0], 32'd1); advance();
        set_p0(1'b1, 1'b0, 32'd21, 32'd0);
        settle(); chk("t2_gnt0_r", g0_o[0], 32'd1); chk("t2_mem_wr", mwr_o[0], 32'd1); advance();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        settle(); chk("t2_mem_rd", mrd_o[0], 32'd1); advance();
        settle(); chk("t2_rvalid0", rv0_o[0], 32'd1); chk("t2_rdata", rdata_o[0], 32'hDEAD); advance();

        // Out-of-range read on port 1.
        set_p1(1'b1, 1'b0, 32'd64, 32'd0);
        settle(); chk("t4_gnt1", g1_o[0], 32'd1); advance();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        settle(); chk("t4_mem_rdwr", {mwr_o[0], mrd_o[0]}, 32'd0); advance();
        settle();
        chk("t4_err1", e1_o[0], 32'd1); chk("t4_rvalid1", rv1_o[0], 32'd1); chk("t4_rdata", rdata_o[0], 32'd0);
        advance();

        // Reset lands on an issued write: nothing commits, nothing returns.
        set_p1(1'b1, 1'b1, 32'd30, 32'h1234);
        settle(); chk("t5_gnt1", g1_o[0], 32'd1); advance();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        settle(); chk("t5_mem_wr", mwr_o[0], 32'd0); chk("t5_gnt_in_rst", {g1_o[0], g0_o[0]}, 32'd0); advance();
        reset = 1'b0;
        settle(); chk("t5_rvalid1", rv1_o[0], 32'd0); chk("t5_err1", e1_o[0], 32'd0); advance();
        set_p0(1'b1, 1'b0, 32'd30, 32'd0);
        settle(); advance();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        settle(); advance();
        settle(); chk("t5_rb_rvalid0", rv0_o[0], 32'd1); chk("t5_rb_rdata", rdata_o[0], 32'd0); advance();

        // Withdrawn request on port 0 while port 1 wins.
        set_p0(1'b1, 1'b0, 32'd1, 32'd0);
        settle(); advance();
        set_p0(1'b1, 1'b0, 32'd2, 32'd0);
        set_p1(1'b1, 1'b0, 32'd3, 32'd0);
        settle(); chk("t6_gnt1", g1_o[0], 32'd1); chk("t6_no_gnt0", g0_o[0], 32'd0); advance();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        settle(); chk("t6_idle_gnt0", g0_o[0], 32'd0); advance();
        settle(); chk("t6_rvalid1", rv1_o[0], 32'd1); chk("t6_no_rvalid0", rv0_o[0], 32'd0); advance();
        settle(); chk("t6_no_rvalid0_late", rv0_o[0], 32'd0); advance();
        set_p0(1'b1, 1'b0, 32'd4, 32'd0);
        set_p1(1'b1, 1'b0, 32'd6, 32'd0);
        settle(); chk("t6_next_conflict_gnt0", g0_o[0], 32'd1); advance();
        idle(3);

        // Random traffic with occasional resets; addresses cluster to provoke RAW hits.
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(60, 70)) : 32'($urandom_range(0, 7)),
                   $urandom);
            set_p1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(60, 70)) : 32'($urandom_range(0, 7)),
                   $urandom);
            settle();
            advance();
        end
        reset = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
